// File: rtl/cordic_pkg.sv
// Shared types and constants for the 16-bit cordic core and its pre-rotation stage.
package cordic_pkg;

   localparam int              W        = 16;
   localparam logic [W-1:0]    HALF_PI  = 16'h3244;
   localparam logic            MODE_ROT = 1'b1;
   localparam logic            MODE_VEC = 1'b0;

   typedef struct packed {
      logic         mode;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W-1:0] z;
      logic         folded;
      logic         sat;
   } cordic_req_t;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } buf_state_e;

   // Returns {saturated, -v}; the most negative value clamps to the most positive.
   function automatic logic [W:0] neg_sat(input logic [W-1:0] v);
      if (v == {1'b1, {(W-1){1'b0}}})
         return {1'b1, 1'b0, {(W-1){1'b1}}};
      else
         return {1'b0, -v};
   endfunction

endpackage

// File: rtl/cordic_prerotate_if.sv
// Request/response bundle between the upstream source, the pre-rotation stage and the core.
interface cordic_prerotate_if #(
   parameter int W = 16
);
   logic         in_valid;
   logic         in_ready;
   logic         in_mode;
   logic [W-1:0] in_x;
   logic [W-1:0] in_y;
   logic [W-1:0] in_z;
   logic         out_valid;
   logic         out_ready;
   logic         out_mode;
   logic [W-1:0] out_x;
   logic [W-1:0] out_y;
   logic [W-1:0] out_z;
   logic         out_folded;
   logic         out_sat;

   modport slave (
      input  in_valid, in_mode, in_x, in_y, in_z, out_ready,
      output in_ready, out_valid, out_mode, out_x, out_y, out_z, out_folded, out_sat
   );

   modport master (
      output in_valid, in_mode, in_x, in_y, in_z, out_ready,
      input  in_ready, out_valid, out_mode, out_x, out_y, out_z, out_folded, out_sat
   );
endinterface

// File: rtl/cordic_prerotate_fold.sv
// Combinational quadrant fold: brings any operand into the core's |angle| <= pi/2 range.
module cordic_fold
   import cordic_pkg::*;
#(
   parameter logic [W-1:0] HP = HALF_PI
) (
   input  logic         mode_i,
   input  logic [W-1:0] x_i,
   input  logic [W-1:0] y_i,
   input  logic [W-1:0] z_i,
   output cordic_req_t  req_o
);

   logic [W:0] nx;
   logic [W:0] ny;

   assign nx = neg_sat(x_i);
   assign ny = neg_sat(y_i);

   always_comb begin
      req_o        = '0;
      req_o.mode   = mode_i;
      req_o.x      = x_i;
      req_o.y      = y_i;
      req_o.z      = z_i;
      if (mode_i == MODE_ROT) begin
         if ($signed(z_i) > $signed(HP)) begin
            req_o.x      = ny[W-1:0];
            req_o.y      = x_i;
            req_o.z      = z_i - HP;
            req_o.folded = 1'b1;
            req_o.sat    = ny[W];
         end else if ($signed(z_i) < -$signed(HP)) begin
            req_o.x      = y_i;
            req_o.y      = nx[W-1:0];
            req_o.z      = z_i + HP;
            req_o.folded = 1'b1;
            req_o.sat    = nx[W];
         end
      end else if (x_i[W-1]) begin
         // Vectoring: left half-plane rotates toward +x by the quadrant of y.
         req_o.folded = 1'b1;
         if (!y_i[W-1]) begin
            req_o.x   = y_i;
            req_o.y   = nx[W-1:0];
            req_o.z   = z_i + HP;
            req_o.sat = nx[W];
         end else begin
            req_o.x   = ny[W-1:0];
            req_o.y   = x_i;
            req_o.z   = z_i - HP;
            req_o.sat = ny[W];
         end
      end
   end

endmodule

// File: rtl/cordic_prerotate.sv
// Pre-rotation input stage with a two-entry (output + skid) buffer and registered in_ready.
// Optional fold counter port fold_count is enabled by defining CORDIC_PREROT_STATS_EN.
module cordic_prerotate #(
   parameter int                W       = cordic_pkg::W,
   parameter logic [W-1:0]      HALF_PI = cordic_pkg::HALF_PI
) (
   input  logic                clk,
   input  logic                reset,
`ifdef CORDIC_PREROT_STATS_EN
   output logic [15:0]         fold_count,
`endif
   cordic_prerotate_if.slave   bus
);
   import cordic_pkg::*;

   cordic_req_t fold_req;
   cordic_req_t out_q, out_d;
   cordic_req_t skid_q, skid_d;
   buf_state_e  state_q, state_d;
   logic        in_ready_q, in_ready_d;
   logic        out_valid_q, out_valid_d;
   logic        accept;
   logic        pop;

   cordic_fold #(.HP(HALF_PI)) u_fold (
      .mode_i (bus.in_mode),
      .x_i    (bus.in_x),
      .y_i    (bus.in_y),
      .z_i    (bus.in_z),
      .req_o  (fold_req)
   );

   assign accept = bus.in_valid & in_ready_q;
   assign pop    = out_valid_q & bus.out_ready;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      case (state_q)
         S_EMPTY: begin
            if (accept) begin
               out_d   = fold_req;
               state_d = S_ONE;
            end
         end
         S_ONE: begin
            case ({accept, pop})
               2'b10: begin
                  skid_d  = fold_req;
                  state_d = S_TWO;
               end
               2'b01: state_d = S_EMPTY;
               2'b11: out_d   = fold_req;
               default: ;
            endcase
         end
         S_TWO: begin
            if (pop) begin
               out_d   = skid_q;
               state_d = S_ONE;
            end
         end
         default: state_d = S_EMPTY;
      endcase
      // Flags are derived from the next state so both leave flops directly.
      out_valid_d = (state_d != S_EMPTY);
      in_ready_d  = (state_d != S_TWO);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_EMPTY;
         out_q       <= '0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         skid_q      <= skid_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_mode   = out_q.mode;
   assign bus.out_x      = out_q.x[W-1:0];
   assign bus.out_y      = out_q.y[W-1:0];
   assign bus.out_z      = out_q.z[W-1:0];
   assign bus.out_folded = out_q.folded;
   assign bus.out_sat    = out_q.sat;

`ifdef CORDIC_PREROT_STATS_EN
   logic [15:0] fold_cnt_q, fold_cnt_d;

   always_comb begin
      fold_cnt_d = fold_cnt_q;
      if (accept && fold_req.folded && (fold_cnt_q != 16'hFFFF))
         fold_cnt_d = fold_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         fold_cnt_q <= '0;
      else
         fold_cnt_q <= fold_cnt_d;
   end

   assign fold_count = fold_cnt_q;
`endif

endmodule

// File: tb/tb_cordic_prerotate.sv
// Scoreboard bench for cordic_prerotate: directed fold/boundary cases, back-pressure, reset, random traffic.
module tb_cordic_prerotate;
   import cordic_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cordic_prerotate_if #(.W(W)) bus ();
`ifdef CORDIC_PREROT_STATS_EN
   logic [15:0] fold_count;
`endif

   cordic_prerotate #(.W(W), .HALF_PI(HALF_PI)) dut (
      .clk        (clk),
      .reset      (reset),
`ifdef CORDIC_PREROT_STATS_EN
      .fold_count (fold_count),
`endif
      .bus        (bus)
   );

   int          vectors     = 0;
   int          miscompares = 0;
   cordic_req_t sb[$];
   cordic_req_t mon_got, mon_exp;
   cordic_req_t got;

   function automatic cordic_req_t mk(bit m, logic [15:0] x, logic [15:0] y, logic [15:0] z,
                                      bit f, bit s);
      cordic_req_t r;
      r.mode = m; r.x = x; r.y = y; r.z = z; r.folded = f; r.sat = s;
      return r;
   endfunction

   // Integer reference model of the fold rule.
   function automatic cordic_req_t model(bit m, logic [15:0] x, logic [15:0] y, logic [15:0] z);
      int sx = $signed(x);
      int sy = $signed(y);
      int sz = $signed(z);
      int hp = 12868;
      int nx = sx;
      int ny = sy;
      int nz = sz;
      bit f = 1'b0;
      bit s = 1'b0;
      if (m) begin
         if (sz > hp) begin
            nx = -sy; ny = sx; nz = sz - hp; f = 1'b1;
         end else if (sz < -hp) begin
            nx = sy; ny = -sx; nz = sz + hp; f = 1'b1;
         end
      end else if (sx < 0) begin
         f = 1'b1;
         if (sy >= 0) begin
            nx = sy; ny = -sx; nz = sz + hp;
         end else begin
            nx = -sy; ny = sx; nz = sz - hp;
         end
      end
      if (nx > 32767) begin nx = 32767; s = 1'b1; end
      if (ny > 32767) begin ny = 32767; s = 1'b1; end
      return mk(m, 16'(nx), 16'(ny), 16'(nz), f, s);
   endfunction

   function automatic cordic_req_t observe();
      return mk(bus.out_mode, bus.out_x, bus.out_y, bus.out_z, bus.out_folded, bus.out_sat);
   endfunction

   always @(negedge clk) begin
      if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         mon_got = observe();
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_output got=%h required=none", mon_got);
         end else begin
            mon_exp = sb.pop_front();
            if (mon_got !== mon_exp) begin
               miscompares++;
               $display("FAIL scoreboard got=%h required=%h", mon_got, mon_exp);
            end
         end
      end
   end

   // Holds the request until accepted; caller is aligned just after a rising edge.
   task automatic send(input bit m, input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
      int  n    = 0;
      bit  done = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_mode  = m;
      bus.in_x     = x;
      bus.in_y     = y;
      bus.in_z     = z;
      while (!done && n < 50) begin
         @(negedge clk);
         if (bus.in_ready === 1'b1) begin
            sb.push_back(model(m, x, y, z));
            done = 1'b1;
         end
         @(posedge clk); #1;
         n++;
      end
      bus.in_valid = 1'b0;
      vectors++;
      if (!done) begin
         miscompares++;
         $display("FAIL send_timeout got=not_accepted required=accepted");
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain got=%0d_left required=0", sb.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++; $display("FAIL reset_out_valid got=%b required=0", bus.out_valid);
      end
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++; $display("FAIL reset_in_ready got=%b required=1", bus.in_ready);
      end
      got = observe();
      vectors++;
      if (got !== '0) begin
         miscompares++; $display("FAIL reset_payload got=%h required=0", got);
      end
`ifdef CORDIC_PREROT_STATS_EN
      vectors++;
      if (fold_count !== 16'h0000) begin
         miscompares++; $display("FAIL reset_fold_count got=%h required=0000", fold_count);
      end
`endif
   endtask

   task automatic check_out(input string name, input cordic_req_t exp);
      got = observe();
      vectors++;
      if (bus.out_valid !== 1'b1 || got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%b/%h required=1/%h", name, bus.out_valid, got, exp);
      end
   endtask

   task automatic test_rotation_fold();
      bus.out_ready = 1'b1;
      send(MODE_ROT, 16'h2000, 16'h0000, 16'h4000);
      check_out("rot_fold", mk(1, 16'h0000, 16'h2000, 16'h0DBC, 1, 0));
      send(MODE_ROT, 16'h8000, 16'h1111, 16'h8000);
      check_out("rot_neg_sat", mk(1, 16'h1111, 16'h7FFF, 16'hB244, 1, 1));
      drain();
   endtask

   task automatic test_boundary();
      bus.out_ready = 1'b1;
      send(MODE_ROT, 16'h1234, 16'h0567, 16'h3244);
      check_out("rot_z_eq_hp", mk(1, 16'h1234, 16'h0567, 16'h3244, 0, 0));
      send(MODE_ROT, 16'h1234, 16'h0567, 16'hCDBC);
      check_out("rot_z_eq_neg_hp", mk(1, 16'h1234, 16'h0567, 16'hCDBC, 0, 0));
      send(MODE_ROT, 16'h1000, 16'h0200, 16'h3245);
      check_out("rot_z_above_hp", mk(1, 16'hFE00, 16'h1000, 16'h0001, 1, 0));
      send(MODE_VEC, 16'h0000, 16'h8000, 16'h0100);
      check_out("vec_x_zero", mk(0, 16'h0000, 16'h8000, 16'h0100, 0, 0));
      drain();
   endtask

   task automatic test_vectoring();
      bus.out_ready = 1'b1;
      send(MODE_VEC, 16'h8000, 16'h0100, 16'h0000);
      check_out("vec_sat", mk(0, 16'h0100, 16'h7FFF, 16'h3244, 1, 1));
      send(MODE_VEC, 16'hF000, 16'hF000, 16'h0000);
      check_out("vec_q3", mk(0, 16'h1000, 16'hF000, 16'hCDBC, 1, 0));
      drain();
   endtask

   task automatic test_backpressure();
      cordic_req_t a, b, c;
      int n;
      bit done;
      a = mk(1, 16'h0AAA, 16'h0111, 16'h4000, 0, 0);
      b = mk(0, 16'hF555, 16'h0222, 16'h0000, 0, 0);
      c = mk(1, 16'h0CCC, 16'h0333, 16'h0100, 0, 0);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_mode = a.mode; bus.in_x = a.x; bus.in_y = a.y; bus.in_z = a.z;
      @(negedge clk);
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++; $display("FAIL bp_accept_a got=%b required=1", bus.in_ready);
      end
      sb.push_back(model(a.mode, a.x, a.y, a.z));
      @(posedge clk); #1;
      bus.in_mode = b.mode; bus.in_x = b.x; bus.in_y = b.y; bus.in_z = b.z;
      @(negedge clk);
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++; $display("FAIL bp_accept_b got=%b required=1", bus.in_ready);
      end
      sb.push_back(model(b.mode, b.x, b.y, b.z));
      @(posedge clk); #1;
      bus.in_mode = c.mode; bus.in_x = c.x; bus.in_y = c.y; bus.in_z = c.z;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (bus.in_ready !== 1'b0 || bus.out_x !== 16'hFEEF) begin
            miscompares++;
            $display("FAIL bp_full_%0d got=rdy%b/x%h required=rdy0/xFEEF", i, bus.in_ready, bus.out_x);
         end
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      n = 0;
      done = 1'b0;
      while (!done && n < 10) begin
         @(negedge clk);
         if (bus.in_ready === 1'b1) begin
            sb.push_back(model(c.mode, c.x, c.y, c.z));
            done = 1'b1;
         end
         @(posedge clk); #1;
         n++;
      end
      bus.in_valid = 1'b0;
      vectors++;
      if (!done) begin
         miscompares++; $display("FAIL bp_accept_c got=not_accepted required=accepted");
      end
      drain();
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 1'b0;
      send(MODE_ROT, 16'h0101, 16'h0202, 16'h7000);
      send(MODE_VEC, 16'h8001, 16'h0303, 16'h0000);
      bus.in_valid = 1'b1;
      bus.in_mode = MODE_ROT; bus.in_x = 16'h0404; bus.in_y = 16'h0505; bus.in_z = 16'h0000;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      bus.in_valid = 1'b0;
      sb.delete();
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid got=vld%b/rdy%b required=vld0/rdy1", bus.out_valid, bus.in_ready);
      end
      bus.out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++; $display("FAIL reset_mid_idle got=%b required=0", bus.out_valid);
      end
   endtask

   task automatic test_back_to_back();
      int t0;
      bit done = 1'b0;
      bus.out_ready = 1'b1;
      t0 = $time;
      for (int i = 0; i < 8; i++)
         send(i[0], 16'(i * 16'h1357), 16'(16'h8000 + i * 16'h0911), 16'(i * 16'h1F00));
      vectors++;
      if (($time - t0) != 80) begin
         miscompares++; $display("FAIL throughput got=%0d required=80", $time - t0);
      end
      fork
         begin
            for (int i = 0; i < 60; i++)
               send(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom));
            done = 1'b1;
         end
         begin
            while (!done) begin
               bus.out_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk); #1;
            end
         end
      join
      bus.out_ready = 1'b1;
      drain();
   endtask

`ifdef CORDIC_PREROT_STATS_EN
   task automatic test_stats();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      bus.out_ready = 1'b1;
      send(MODE_ROT, 16'h2000, 16'h0000, 16'h4000);
      send(MODE_ROT, 16'h2000, 16'h0000, 16'h0100);
      send(MODE_VEC, 16'h8000, 16'h0100, 16'h0000);
      send(MODE_VEC, 16'h0100, 16'h0100, 16'h0000);
      send(MODE_ROT, 16'h2000, 16'h0000, 16'hA000);
      drain();
      vectors++;
      if (fold_count !== 16'd3) begin
         miscompares++; $display("FAIL fold_count got=%0d required=3", fold_count);
      end
   endtask
`endif

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_mode   = 1'b0;
      bus.in_x      = '0;
      bus.in_y      = '0;
      bus.in_z      = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_rotation_fold();
      test_boundary();
      test_vectoring();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
`ifdef CORDIC_PREROT_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cordic_prerotate.md
# cordic_prerotate

Upstream input stage for the 16-bit `cordic` core.
- Accepts `(mode, x, y, z)` requests over a valid/ready handshake.
- Performs quadrant pre-rotation so every operand handed to the core lies inside its convergence range (|angle| ≤ π/2).
- Buffers up to two requests so `in_ready` is a registered signal and back-pressure from the core does not create a combinational path.

## Interface
Parameters:
- `W`, 16: data width of x, y, z (two's complement).
- `HALF_PI`, 16'h3244: π/2 in z format, Q2.13 radians.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: stage can accept a request. Registered.
- `in_mode` in 1: 1 = rotation, 0 = vectoring.
- `in_x`, `in_y`, `in_z` in W: operands, signed.
- `out_valid` out 1: folded request present for the core.
- `out_ready` in 1: core accepts the request.
- `out_mode` out 1: mode, passed through unchanged.
- `out_x`, `out_y`, `out_z` out W: folded operands.
- `out_folded` out 1: a ±90° fold was applied.
- `out_sat` out 1: a negation saturated.
- `fold_count` out 16: present only with `CORDIC_PREROT_STATS_EN`.

## Operation
Fold rule, applied at acceptance and registered with the request:
- Rotation, z > HALF_PI (strict): x' = −y, y' = x, z' = z − HALF_PI.
- Rotation, z < −HALF_PI (strict): x' = y, y' = −x, z' = z + HALF_PI.
- Vectoring, x < 0 and y ≥ 0: x' = y, y' = −x, z' = z + HALF_PI.
- Vectoring, x < 0 and y < 0: x' = −y, y' = x, z' = z − HALF_PI.
- Otherwise: pass through unchanged, `out_folded` = 0.

Arithmetic:
- Negation of 16'h8000 saturates to 16'h7FFF and sets `out_sat`.
- z add/subtract wraps modulo 2^16; no saturation.
- A request is never folded more than once.

Buffer state machine. State is the occupancy of the output register plus one skid register:
- EMPTY: `out_valid` = 0, `in_ready` = 1. Accept → ONE.
- ONE: `out_valid` = 1, `in_ready` = 1.
  - Accept with no pop → TWO.
  - Pop with no accept → EMPTY.
  - Accept and pop together → stay ONE; the new request moves into the output register.
- TWO: `out_valid` = 1, `in_ready` = 0. Pop → ONE; the skid entry moves into the output register.
- Order is strictly FIFO.
- `in_valid` while `in_ready` = 0 is ignored; the upstream source must hold it.
- `out_*` payload is stable while `out_valid` = 1 and `out_ready` = 0.

## Timing
- Latency: request accepted at edge N → visible on `out_*` at edge N, with `out_valid` = 1 during cycle N+1.
- Throughput: one request per cycle while `out_ready` = 1.
- `in_ready` deasserts in the cycle after the second entry is captured; it reasserts the cycle after a pop from TWO.
- Reset values: `out_valid` 0, `in_ready` 1, `out_mode` 0, `out_x` / `out_y` / `out_z` 0, `out_folded` 0, `out_sat` 0, `fold_count` 0.
- Reset mid-operation discards both entries. A handshake coincident with reset is dropped.

## Configuration
- `CORDIC_PREROT_STATS_EN` defined:
  - `fold_count` port exists.
  - It increments on every accepted request with a fold applied.
  - It saturates at 16'hFFFF and clears on reset.
- `CORDIC_PREROT_STATS_EN` not defined: no port, no counter logic; all other behaviour is identical.

## Structure
Package `cordic_pkg`:
- `W`, `HALF_PI`, `MODE_ROT` = 1, `MODE_VEC` = 0.
- Packed struct `cordic_req_t` {mode, x, y, z, folded, sat}.
- This package is shared with `cordic`.

Sub-module `cordic_fold`: combinational fold rule plus saturating negate. The top level holds the two-entry buffer and the counter.

## Test plan
- Rotation fold: x=16'h2000, y=0, z=16'h4000, out_ready=1 → next cycle out_x=0, out_y=16'h2000, out_z=16'h0DBC, out_folded=1.
- Boundary: rotation z=16'h3244 → passes unchanged, out_folded=0. z=16'hCDBC (−HALF_PI) → also unchanged.
- Vectoring saturation: x=16'h8000, y=16'h0100, z=0 → out_x=16'h0100, out_y=16'h7FFF, out_z=16'h3244, out_sat=1.
- Back-pressure: out_ready=0 with in_valid held for 3 cycles carrying A, B, C → A and B accepted, in_ready=0 from the third cycle. Raise out_ready → A, B, C emitted in order, no loss or duplication.
- Reset mid-op: while in state TWO, assert reset one cycle → next cycle out_valid=0, in_ready=1, and the held entries never appear.
- With `CORDIC_PREROT_STATS_EN`: 5 requests, 3 of them folding → fold_count=3.
